// File: rtl/isp_wb_pkg.sv
// isp_wb_pkg: shared constants and helpers for the
// raw-domain white-balance and Bayer-site blocks.
package isp_wb_pkg;

  localparam logic [1:0] SITE_R  = 2'd0;
  localparam logic [1:0] SITE_GR = 2'd1;
  localparam logic [1:0] SITE_GB = 2'd2;
  localparam logic [1:0] SITE_B  = 2'd3;

  localparam int PIPE_LAT = 3;

  function automatic int unity_gain(int frac);
    return 1 << frac;
  endfunction

  function automatic int round_half(int frac);
    return (frac > 0) ? (1 << (frac - 1)) : 0;
  endfunction

endpackage

// File: rtl/isp_bayer_phase.sv
// isp_bayer_phase: tracks pixel/line parity and
// reports the CFA site of the current raw sample.
module isp_bayer_phase #(
  parameter int BAYER = 0
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       in_href,
  input  logic       in_vsync,
  output logic [1:0] site
);

  logic odd_pix;
  logic odd_line;
  logic href_q;

  // parity of pixel within line and of line within frame
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      odd_pix  <= 1'b0;
      odd_line <= 1'b0;
      href_q   <= 1'b0;
    end else begin
      href_q  <= in_href;
      odd_pix <= in_href ? ~odd_pix : 1'b0;
      if (in_vsync)
        odd_line <= 1'b0;
      else if (href_q && !in_href)
        odd_line <= ~odd_line;
    end
  end

  assign site = 2'(BAYER) ^ {odd_line, odd_pix};

endmodule

// File: rtl/isp_wb_gain4.sv
// isp_wb_gain4: frame-synchronous per-site Bayer gain
// with rounding, clipping, bypass and clip statistic.
module isp_wb_gain4
  import isp_wb_pkg::*;
#(
  parameter int BITS      = 8,
  parameter int GAIN_BITS = 12,
  parameter int FRAC_BITS = 8,
  parameter int BAYER     = 0,
  parameter int CNT_BITS  = 24
) (
  input  logic                 pclk,
  input  logic                 rst_n,
  input  logic [GAIN_BITS-1:0] gain_r,
  input  logic [GAIN_BITS-1:0] gain_gr,
  input  logic [GAIN_BITS-1:0] gain_gb,
  input  logic [GAIN_BITS-1:0] gain_b,
  input  logic                 bypass,
  input  logic                 in_href,
  input  logic                 in_vsync,
  input  logic [BITS-1:0]      in_raw,
  output logic                 out_href,
  output logic                 out_vsync,
  output logic [BITS-1:0]      out_raw,
  output logic [CNT_BITS-1:0]  clip_cnt,
  output logic                 clip_cnt_valid
);

  localparam int PW = BITS + GAIN_BITS;
  localparam logic [GAIN_BITS-1:0] UNITY =
    GAIN_BITS'(unity_gain(FRAC_BITS));
  localparam logic [PW:0] HALF =
    (PW+1)'(round_half(FRAC_BITS));

  logic                 vsync_q;
  logic [GAIN_BITS-1:0] g_r, g_gr, g_gb, g_b;
  logic                 byp_act;
  logic [1:0]           site;

  logic [BITS-1:0]      raw1;
  logic [1:0]           site1;
  logic                 href1, vsync1;

  logic [PW-1:0]        prod2;
  logic [BITS-1:0]      raw2;
  logic                 href2, vsync2, byp2;

  logic [GAIN_BITS-1:0] gsel;
  logic [PW:0]          rnd;
  logic [PW:0]          val;
  logic                 over;
  logic [BITS-1:0]      pix;
  logic                 clip3;
  logic                 rise3;

  logic [CNT_BITS-1:0]  acc;
  logic                 seen;

  isp_bayer_phase #(
    .BAYER(BAYER)
  ) u_phase (
    .pclk    (pclk),
    .rst_n   (rst_n),
    .in_href (in_href),
    .in_vsync(in_vsync),
    .site    (site)
  );

  // shadow gains and bypass at frame start
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      g_r     <= UNITY;
      g_gr    <= UNITY;
      g_gb    <= UNITY;
      g_b     <= UNITY;
      byp_act <= 1'b0;
    end else begin
      vsync_q <= in_vsync;
      if (in_vsync && !vsync_q) begin
        g_r     <= gain_r;
        g_gr    <= gain_gr;
        g_gb    <= gain_gb;
        g_b     <= gain_b;
        byp_act <= bypass;
      end
    end
  end

  // stage 1: capture sample and its site
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      raw1   <= '0;
      site1  <= '0;
      href1  <= 1'b0;
      vsync1 <= 1'b0;
    end else begin
      raw1   <= in_raw;
      site1  <= site;
      href1  <= in_href;
      vsync1 <= in_vsync;
    end
  end

  // pick the active gain for the stage-1 site
  always_comb begin
    gsel = g_r;
    case (site1)
      SITE_R:  gsel = g_r;
      SITE_GR: gsel = g_gr;
      SITE_GB: gsel = g_gb;
      SITE_B:  gsel = g_b;
    endcase
  end

  // stage 2: full-width product
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      prod2  <= '0;
      raw2   <= '0;
      href2  <= 1'b0;
      vsync2 <= 1'b0;
      byp2   <= 1'b0;
    end else begin
      prod2  <= PW'(raw1) * PW'(gsel);
      raw2   <= raw1;
      href2  <= href1;
      vsync2 <= vsync1;
      byp2   <= byp_act;
    end
  end

  // round to nearest and saturate
  always_comb begin
    rnd   = {1'b0, prod2} + HALF;
    val   = rnd >> FRAC_BITS;
    over  = |val[PW:BITS];
    pix   = over ? '1 : val[BITS-1:0];
    clip3 = href2 && !byp2 && over;
    rise3 = vsync2 && !out_vsync;
  end

  // stage 3: registered outputs
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      out_href  <= 1'b0;
      out_vsync <= 1'b0;
      out_raw   <= '0;
    end else begin
      out_href  <= href2;
      out_vsync <= vsync2;
      if (!href2)
        out_raw <= '0;
      else if (byp2)
        out_raw <= raw2;
      else
        out_raw <= pix;
    end
  end

  // per-frame clip count, reported at output frame start
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      acc            <= '0;
      seen           <= 1'b0;
      clip_cnt       <= '0;
      clip_cnt_valid <= 1'b0;
    end else begin
      clip_cnt_valid <= 1'b0;
      if (rise3) begin
        seen <= 1'b1;
        acc  <= CNT_BITS'(clip3);
        if (seen) begin
          clip_cnt       <= acc;
          clip_cnt_valid <= 1'b1;
        end
      end else if (clip3 && acc != '1) begin
        acc <= acc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_isp_wb_gain4.sv
// tb_isp_wb_gain4: random frames on RGGB and BGGR
// instances checked against a frame-level model.
module tb_isp_wb_gain4;

  localparam int BITS = 8;
  localparam int GAIN_BITS = 12;
  localparam int FRAC_BITS = 8;
  localparam int CNT_BITS = 24;

  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  logic [GAIN_BITS-1:0] gain_r, gain_gr;
  logic [GAIN_BITS-1:0] gain_gb, gain_b;
  logic bypass;
  logic in_href, in_vsync;
  logic [BITS-1:0] in_raw;

  logic [1:0] oh, ov, cv;
  logic [BITS-1:0] oraw [2];
  logic [CNT_BITS-1:0] ccnt [2];

  int total = 0;
  int bad = 0;

  always #5 pclk = ~pclk;

  isp_wb_gain4 #(
    .BITS(BITS), .GAIN_BITS(GAIN_BITS),
    .FRAC_BITS(FRAC_BITS), .BAYER(0),
    .CNT_BITS(CNT_BITS)
  ) u_dut0 (
    .pclk(pclk), .rst_n(rst_n),
    .gain_r(gain_r), .gain_gr(gain_gr),
    .gain_gb(gain_gb), .gain_b(gain_b),
    .bypass(bypass),
    .in_href(in_href), .in_vsync(in_vsync),
    .in_raw(in_raw),
    .out_href(oh[0]), .out_vsync(ov[0]),
    .out_raw(oraw[0]), .clip_cnt(ccnt[0]),
    .clip_cnt_valid(cv[0])
  );

  isp_wb_gain4 #(
    .BITS(BITS), .GAIN_BITS(GAIN_BITS),
    .FRAC_BITS(FRAC_BITS), .BAYER(3),
    .CNT_BITS(CNT_BITS)
  ) u_dut1 (
    .pclk(pclk), .rst_n(rst_n),
    .gain_r(gain_r), .gain_gr(gain_gr),
    .gain_gb(gain_gb), .gain_b(gain_b),
    .bypass(bypass),
    .in_href(in_href), .in_vsync(in_vsync),
    .in_raw(in_raw),
    .out_href(oh[1]), .out_vsync(ov[1]),
    .out_raw(oraw[1]), .clip_cnt(ccnt[1]),
    .clip_cnt_valid(cv[1])
  );

  typedef struct {
    int h;
    int v;
    int raw;
    int cnt;
    int val;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // frame-level reference state
  int pv, ph, px, py;
  int ag[4];
  int ab;
  int fcnt[2];
  int seen[2];
  int lastc[2];

  task automatic chk(string tag, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int gained(int raw, int g);
    longint p;
    p = longint'(raw) * longint'(g);
    p = p + (longint'(1) << (FRAC_BITS - 1));
    return int'(p >> FRAC_BITS);
  endfunction

  task automatic model_reset();
    exp_t z;
    z = '{0, 0, 0, 0, 0};
    pv = 0; ph = 0; px = 0; py = 0;
    for (int i = 0; i < 4; i++)
      ag[i] = 1 << FRAC_BITS;
    ab = 0;
    for (int d = 0; d < 2; d++) begin
      fcnt[d] = 0; seen[d] = 0; lastc[d] = 0;
    end
    q0.delete();
    q1.delete();
    q0.push_back(z); q0.push_back(z);
    q1.push_back(z); q1.push_back(z);
  endtask

  task automatic model_step(int h, int v, int raw);
    int rise, site, val, clip, o, pulse;
    exp_t e;
    rise = (v != 0 && pv == 0) ? 1 : 0;
    if (rise != 0) begin
      ag[0] = int'(gain_r);
      ag[1] = int'(gain_gr);
      ag[2] = int'(gain_gb);
      ag[3] = int'(gain_b);
      ab = int'(bypass);
    end
    for (int d = 0; d < 2; d++) begin
      site = (d == 0 ? 0 : 3)
             ^ ((py % 2) * 2 + (px % 2));
      val = gained(raw, ag[site]);
      clip = (h != 0 && ab == 0 && val > 255);
      if (h == 0) o = 0;
      else if (ab != 0) o = raw;
      else o = (val > 255) ? 255 : val;
      pulse = 0;
      if (rise != 0) begin
        if (seen[d] != 0) begin
          pulse = 1;
          lastc[d] = fcnt[d];
        end
        seen[d] = 1;
        fcnt[d] = clip;
      end else begin
        fcnt[d] += clip;
      end
      e = '{h, v, o, lastc[d], pulse};
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    px = (h != 0) ? px + 1 : 0;
    if (v != 0) py = 0;
    else if (ph != 0 && h == 0) py = py + 1;
    pv = v;
    ph = h;
  endtask

  task automatic compare();
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("href%0d", d), int'(oh[d]), e.h);
      chk($sformatf("vsync%0d", d), int'(ov[d]), e.v);
      chk($sformatf("raw%0d", d), int'(oraw[d]), e.raw);
      chk($sformatf("ccnt%0d", d), int'(ccnt[d]), e.cnt);
      chk($sformatf("cval%0d", d), int'(cv[d]), e.val);
    end
  endtask

  task automatic cyc(int h, int v, int raw);
    in_href = h[0];
    in_vsync = v[0];
    in_raw = raw[7:0];
    @(posedge pclk);
    model_step(h, v, raw & 255);
    #1;
    compare();
  endtask

  task automatic do_reset();
    in_href = 1'b0;
    in_vsync = 1'b0;
    in_raw = '0;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_href", int'(oh[d]), 0);
      chk("rst_vsync", int'(ov[d]), 0);
      chk("rst_raw", int'(oraw[d]), 0);
      chk("rst_ccnt", int'(ccnt[d]), 0);
      chk("rst_cval", int'(cv[d]), 0);
    end
    @(posedge pclk);
    @(posedge pclk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_gains();
    int k;
    k = $urandom_range(0, 9);
    gain_r  = GAIN_BITS'($urandom_range(0, 1023));
    gain_gr = GAIN_BITS'($urandom_range(0, 1023));
    gain_gb = GAIN_BITS'($urandom_range(0, 1023));
    gain_b  = GAIN_BITS'($urandom_range(0, 4095));
    if (k == 0) gain_gr = '0;
    if (k == 1) gain_r = '1;
  endtask

  // rawc < 0 selects random pixels; mid 1 doubles R
  // and flips bypass, mid 2 re-randomises all
  task automatic frame(int lines, int pix, int vs,
                       int rawc, int mid);
    for (int i = 0; i < vs; i++)
      cyc(0, 1, $urandom_range(0, 255));
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    for (int l = 0; l < lines; l++) begin
      if (l == lines / 2 && mid == 1) begin
        gain_r = 12'd512;
        bypass = ~bypass;
      end
      if (l == lines / 2 && mid == 2) begin
        rand_gains();
        bypass = 1'($urandom_range(0, 1));
      end
      for (int p = 0; p < pix; p++)
        cyc(1, 0, rawc < 0
                  ? int'($urandom_range(0, 255))
                  : rawc);
      for (int b = 0; b < 3; b++)
        cyc(0, 0, 0);
    end
  endtask

  initial begin
    gain_r = 12'd256;
    gain_gr = 12'd256;
    gain_gb = 12'd256;
    gain_b = 12'd256;
    bypass = 1'b0;
    in_href = 1'b0;
    in_vsync = 1'b0;
    in_raw = '0;
    do_reset();

    frame(2, 6, 2, 100, 0);

    gain_r = 12'd512;
    gain_b = 12'd384;
    frame(2, 4, 1, 100, 0);
    frame(2, 4, 1, 3, 0);
    frame(2, 4, 1, 1, 0);

    gain_r = 12'd4095;
    gain_gr = 12'd256;
    gain_gb = 12'd256;
    gain_b = 12'd256;
    frame(4, 10, 1, 200, 0);
    gain_r = 12'd256;
    frame(2, 4, 1, -1, 0);
    chk("clip10_rggb", int'(ccnt[0]), 10);
    chk("clip10_bggr", int'(ccnt[1]), 10);

    frame(4, 6, 1, 100, 1);
    frame(2, 6, 1, 100, 0);
    frame(4, 6, 1, -1, 1);
    frame(2, 6, 1, -1, 0);

    bypass = 1'b1;
    gain_r = 12'd4095;
    frame(3, 6, 1, -1, 0);
    frame(2, 4, 1, -1, 0);
    bypass = 1'b0;

    for (int f = 0; f < 20; f++) begin
      rand_gains();
      bypass = ($urandom_range(0, 3) == 0);
      frame($urandom_range(2, 5),
            $urandom_range(2, 12),
            $urandom_range(1, 3), -1,
            $urandom_range(0, 2));
    end

    cyc(0, 1, 0);
    cyc(0, 0, 0);
    for (int p = 0; p < 5; p++)
      cyc(1, 0, $urandom_range(0, 255));
    do_reset();
    gain_r = 12'd300;
    frame(2, 5, 1, -1, 0);
    frame(3, 5, 1, -1, 0);
    frame(2, 5, 1, -1, 0);
    for (int i = 0; i < 5; i++)
      cyc(0, 0, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
